// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store engine: funct3 encodings,
// FSM states and the lane/alignment helpers used at issue time.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } mau_state_e;

  // Any encoding that is not a byte or halfword access behaves as a word.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 1'b1;
      F3_H, F3_HU: return ~off[0];
      default:     return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << off;
      F3_H, F3_HU: return 4'b0011 << off;
      default:     return 4'b1111;
    endcase
  endfunction

  // Replicating the low byte/half puts it on every lane; byte enables pick the live one.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_B, F3_BU: return {4{data[7:0]}};
      F3_H, F3_HU: return {2{data[15:0]}};
      default:     return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Picks the addressed byte/halfword out of a bus word and sign- or
// zero-extends it; purely combinational so other refill paths can share it.
module load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    byte_sel  = shifted[7:0];
    half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one word-aligned bus request per memory
// op, stalls the pipeline until the handshake completes and formats load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        wb_wren,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  mau_state_e       state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       offset_q;
  logic [2:0]       funct3_q;
  logic             op;
  logic             aligned;
  logic             timeout_hit;
  logic [31:0]      fmt_data;

  assign op      = ex_valid & (ex_mem_read | ex_mem_write);
  assign aligned = is_aligned(ex_funct3, ex_addr[1:0]);
  assign wb_wren = ~stall;

  // Offset/funct3 come from the values latched at issue, not the live EX/MEM ones.
  load_formatter u_load_formatter (
    .rdata     (mem_rdata),
    .offset    (offset_q),
    .funct3    (funct3_q),
    .load_data (fmt_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    stall       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = op;
        if (op) next_state = aligned ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        stall       = 1'b1;
        timeout_hit = (TIMEOUT != 0) && !mem_ready && (wait_cnt == TO_LAST);
        if (mem_ready || timeout_hit) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Error flags default low so each one is a single-cycle pulse into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      load_data  <= '0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      wait_cnt   <= '0;
      offset_q   <= '0;
      funct3_q   <= '0;
    end else begin
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op && aligned) begin
            mem_req   <= 1'b1;
            mem_we    <= ex_mem_write & ~ex_mem_read;
            mem_addr  <= {ex_addr[31:2], 2'b00};
            mem_be    <= byte_enable(ex_funct3, ex_addr[1:0]);
            mem_wdata <= store_lanes(ex_funct3, ex_store_data);
            offset_q  <= ex_addr[1:0];
            funct3_q  <= ex_funct3;
            wait_cnt  <= '0;
          end else if (op) begin
            misaligned <= 1'b1;
            load_data  <= '0;
          end
        end
        ST_WAIT: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) load_data <= fmt_data;
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            load_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: wait_cnt <= '0;
        default: wait_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives EX/MEM ops, plays a simple bus
// responder and compares against hand-computed results.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_store_data = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] load_data;
  logic        stall;
  logic        wb_wren;
  logic        misaligned;
  logic        bus_error;

  int total = 0;
  int bad = 0;

  int          obs_stalls;
  int          obs_req_cycles;
  logic        obs_saw_req, obs_we, obs_mis, obs_berr, obs_wren;
  logic        obs_mis_after, obs_berr_after;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_load;

  mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ex_valid      (ex_valid),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .ex_addr       (ex_addr),
    .ex_store_data (ex_store_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .load_data     (load_data),
    .stall         (stall),
    .wb_wren       (wb_wren),
    .misaligned    (misaligned),
    .bus_error     (bus_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs one op until wb_wren rises; ready_delay < 0 means the bus never answers.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input int ready_delay);
    int   wait_cnt;
    logic done;
    wait_cnt = 0;
    done = 1'b0;
    obs_stalls = 0; obs_req_cycles = 0;
    obs_saw_req = 1'b0; obs_we = 1'b0; obs_mis = 1'b0; obs_berr = 1'b0; obs_wren = 1'b0;
    obs_be = '0; obs_addr = '0; obs_wdata = '0; obs_load = '0;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
    ex_funct3 = f3; ex_addr = addr; ex_store_data = sdata;
    for (int cyc = 0; cyc < 40; cyc++) begin
      mem_ready = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
      if (mem_req) begin
        obs_saw_req = 1'b1;
        obs_req_cycles++;
        obs_be = mem_be; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
        if (ready_delay >= 0 && wait_cnt == ready_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rdata;
        end
        wait_cnt++;
      end
      @(negedge clk);
      if (misaligned) obs_mis = 1'b1;
      if (bus_error) obs_berr = 1'b1;
      if (stall) obs_stalls++;
      else begin
        done = 1'b1;
        obs_load = load_data;
        obs_wren = wb_wren;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) checkOutput("op_done_bound", 32'(done), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    obs_mis_after = misaligned;
    obs_berr_after = bus_error;
  endtask

  initial begin
    #2;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_wb_wren", 32'(wb_wren), 32'd1);
    checkOutput("rst_load_data", load_data, 32'h0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    #10 reset_n = 1'b1;

    applyStimulus(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    checkOutput("lw_stalls", 32'(obs_stalls), 32'd2);
    checkOutput("lw_be", 32'(obs_be), 32'hF);
    checkOutput("lw_addr", obs_addr, 32'h100);
    checkOutput("lw_we", 32'(obs_we), 32'd0);
    checkOutput("lw_req_cycles", 32'(obs_req_cycles), 32'd1);
    checkOutput("lw_wren", 32'(obs_wren), 32'd1);
    checkOutput("lw_load", obs_load, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_FFFF, 0);
    checkOutput("lb_be", 32'(obs_be), 32'h8);
    checkOutput("lb_addr", obs_addr, 32'h100);
    checkOutput("lb_load", obs_load, 32'hFFFF_FF80);

    applyStimulus(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF_FFFF, 0);
    checkOutput("lbu_load", obs_load, 32'h0000_0080);

    applyStimulus(1'b1, 1'b0, F3_H, 32'h102, 32'h0, 32'h8001_1234, 0);
    checkOutput("lh_be", 32'(obs_be), 32'hC);
    checkOutput("lh_load", obs_load, 32'hFFFF_8001);

    applyStimulus(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 32'h8001_1234, 0);
    checkOutput("lhu_load", obs_load, 32'h0000_8001);

    applyStimulus(1'b1, 1'b0, F3_B, 32'h101, 32'h0, 32'h0000_7F00, 1);
    checkOutput("lb1_be", 32'(obs_be), 32'h2);
    checkOutput("lb1_stalls", 32'(obs_stalls), 32'd3);
    checkOutput("lb1_load", obs_load, 32'h0000_007F);

    applyStimulus(1'b0, 1'b1, F3_H, 32'h102, 32'h1234_ABCD, 32'hFFFF_FFFF, 2);
    checkOutput("sh_we", 32'(obs_we), 32'd1);
    checkOutput("sh_be", 32'(obs_be), 32'hC);
    checkOutput("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    checkOutput("sh_stalls", 32'(obs_stalls), 32'd4);
    checkOutput("sh_load_kept", obs_load, 32'h0000_007F);

    applyStimulus(1'b0, 1'b1, F3_B, 32'h101, 32'h0000_00A5, 32'h0, 0);
    checkOutput("sb_be", 32'(obs_be), 32'h2);
    checkOutput("sb_wdata", obs_wdata, 32'hA5A5_A5A5);

    applyStimulus(1'b0, 1'b1, 3'b011, 32'h104, 32'hCAFE_F00D, 32'h0, 0);
    checkOutput("sw_unk_be", 32'(obs_be), 32'hF);
    checkOutput("sw_unk_addr", obs_addr, 32'h104);
    checkOutput("sw_unk_wdata", obs_wdata, 32'hCAFE_F00D);

    applyStimulus(1'b1, 1'b0, F3_W, 32'h101, 32'h0, 32'h1111_1111, 0);
    checkOutput("mis_no_req", 32'(obs_saw_req), 32'd0);
    checkOutput("mis_pulse", 32'(obs_mis), 32'd1);
    checkOutput("mis_pulse_end", 32'(obs_mis_after), 32'd0);
    checkOutput("mis_stalls", 32'(obs_stalls), 32'd1);
    checkOutput("mis_load", obs_load, 32'h0);

    applyStimulus(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 32'h1122_3344, 0);
    checkOutput("lw2_load", obs_load, 32'h1122_3344);

    applyStimulus(1'b1, 1'b0, F3_W, 32'h204, 32'h0, 32'h0, -1);
    checkOutput("to_req_cycles", 32'(obs_req_cycles), 32'd4);
    checkOutput("to_berr", 32'(obs_berr), 32'd1);
    checkOutput("to_berr_end", 32'(obs_berr_after), 32'd0);
    checkOutput("to_stalls", 32'(obs_stalls), 32'd5);
    checkOutput("to_load", obs_load, 32'h0);

    applyStimulus(1'b1, 1'b0, 3'b110, 32'h208, 32'h0, 32'h89AB_CDEF, 0);
    checkOutput("lw_unk_load", obs_load, 32'h89AB_CDEF);

    applyStimulus(1'b1, 1'b0, F3_H, 32'h103, 32'h0, 32'h2222_2222, 0);
    checkOutput("mis_h_no_req", 32'(obs_saw_req), 32'd0);
    checkOutput("mis_h_pulse", 32'(obs_mis), 32'd1);
    checkOutput("mis_h_load", obs_load, 32'h0);

    // Reset in the middle of a stalled load, then a stray ready in IDLE.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = F3_W; ex_addr = 32'h300;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_pre_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    #1;
    checkOutput("rst_mid_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mid_stall", 32'(stall), 32'd0);
    checkOutput("rst_mid_be", 32'(mem_be), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("stray_req", 32'(mem_req), 32'd0);
    checkOutput("stray_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("stray_load", load_data, 32'h0);
    checkOutput("stray_berr", 32'(bus_error), 32'd0);

    applyStimulus(1'b1, 1'b0, F3_W, 32'h304, 32'h0, 32'h0BAD_F00D, 1);
    checkOutput("post_rst_addr", obs_addr, 32'h304);
    checkOutput("post_rst_stalls", 32'(obs_stalls), 32'd3);
    checkOutput("post_rst_load", obs_load, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine. It sits between the EX/MEM pipeline register and the data-memory bus.
- It accepts one memory op per instruction and issues a single word-aligned bus request with byte enables.
- It waits for the bus handshake, then formats load data (LB/LH/LW/LBU/LHU sign/zero extension) for the MEM/WB register's ram_data input.
- It drives the pipeline stall and the MEM/WB write enable.

Parameters:
- TIMEOUT, 255: max cycles in WAIT before bus_error is raised. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store (read and write both high is illegal; read wins)
- ex_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  32  effective byte address
- ex_store_data  in  32  rs2 value, unshifted
- mem_req  out  1  bus request, held until mem_ready
- mem_we  out  1  1 = write
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data shifted to byte lane
- mem_ready  in  1  bus accepts/completes the request this cycle
- mem_rdata  in  32  read word, valid when mem_ready & !mem_we
- load_data  out  32  formatted load result, to MEM/WB ram_data
- stall  out  1  freeze IF/ID/EX and the EX/MEM register
- wb_wren  out  1  MEM/WB write enable (= !stall)
- misaligned  out  1  one-cycle pulse on a misaligned access
- bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data, misaligned, bus_error, timeout counter all 0. stall=0 and wb_wren=1 follow from IDLE.
- States: IDLE, WAIT, DONE.
- op = ex_valid & (ex_mem_read | ex_mem_write).
- Alignment check: H/HU require addr[0]=0; W requires addr[1:0]=0; B/BU are always aligned.
- IDLE:
  - op & aligned: register mem_addr/mem_be/mem_wdata/mem_we, set mem_req=1, go to WAIT. stall=1 combinationally in this same cycle.
  - op & misaligned: no request; misaligned=1 next cycle; load_data=0; go to DONE. stall=1 this cycle.
  - !op: stall=0; load_data holds its value.
- WAIT: mem_req=1 and all bus outputs stable.
  - mem_ready=1: drop mem_req next edge; loads capture the formatted mem_rdata into load_data; go to DONE. stall=1 in this cycle.
  - mem_ready=0: counter increments. If counter==TIMEOUT-1 and TIMEOUT!=0: drop mem_req, bus_error=1 next cycle, load_data=0, go to DONE.
- DONE: stall=0 (wb_wren=1), so MEM/WB latches the instruction with load_data. Counter clears. Next state is IDLE. The EX/MEM contents are now new, so no double issue.
- Total latency: an op costs 2 + (wait cycles) stalled cycles; zero-wait bus gives stall for 2 cycles.
- Byte enables: B 0001<<a[1:0]; H 0011<<a[1:0]; W 1111. wdata: B replicates byte x4, H replicates half x2, W passes through.
- Load format: select lane by a[1:0] latched at issue (not live ex_addr). B/H sign-extend; BU/HU zero-extend.
- Unknown funct3: treated as W.
- Reset mid-WAIT: mem_req drops immediately (async). Any pending bus response is ignored.
- mem_ready in IDLE or DONE: ignored.

Decomposition:
- Shared package: funct3 encodings (F3_B/H/W/BU/HU) and state enum.
- One sub-module, load_formatter: combinational, takes rdata, offset and funct3, returns load_data. It is reused by any future cache refill path.

Test Plan:
- LW 0x100, mem_rdata=0xDEADBEEF, ready on first WAIT cycle -> mem_be=1111, mem_addr=0x100, stall high exactly 2 cycles, load_data=0xDEADBEEF when wb_wren=1.
- LB 0x103, rdata=0x80FFFFFF -> be=1000, load_data=0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH 0x102, store_data=0x1234ABCD -> mem_we=1, be=1100, wdata=0xABCDABCD, no change to load_data.
- LW 0x101 -> no mem_req, misaligned pulse 1 cycle, load_data=0, stall 1 cycle.
- LW with mem_ready held low, TIMEOUT=4 -> mem_req high 4 cycles, then bus_error pulse and return to IDLE.
- reset_n low during WAIT -> mem_req=0 immediately, state IDLE. A later mem_ready is ignored, and the next op issues normally.
